cdb_writeback_arbiter: RTL and testbench
========================================

// Module: cdb_writeback_arbiter
// PURPOSE
//  Shares the single Common Data Bus between the execution units (int, mult, div, mem).
//  Each unit hands its finished result (ROB tag + data) to a 1-entry holding buffer here.
//  A round-robin arbiter picks one buffered result per cycle and drives it onto a registered CDB.
//  The CDB feeds the reservation stations, the register status table and the ROB.
//  Unit stall is by backpressure on req_ready only.
// PARAMETERS
//  DATA_W  32  result data width
//  TAG_W   6   ROB/RS tag width
//  N_REQ   4   number of requesters; index 0=int, 1=mult, 2=div, 3=mem; legal range 2..8
// PORTS
//  clk        in   1             clock, rising edge
//  rst        in   1             reset, synchronous, active-high
//  flush      in   1             mispredict flush; drop all buffered results
//  req_valid  in   N_REQ         unit i presents a result
//  req_tag    in   N_REQ*TAG_W   tag of unit i at [i*TAG_W +: TAG_W]
//  req_data   in   N_REQ*DATA_W  data of unit i at [i*DATA_W +: DATA_W]
//  req_ready  out  N_REQ         buffer i can accept this cycle
//  cdb_valid  out  1             CDB broadcast valid
//  cdb_tag    out  TAG_W         broadcast tag
//  cdb_data   out  DATA_W        broadcast data
//  cdb_src    out  $clog2(N_REQ) index of the unit that produced the broadcast
// BEHAVIOUR
//  - Reset values (rst high at the clock edge):
//    - buf_valid = 0, rr_ptr = 0.
//    - cdb_valid = 0, cdb_tag = 0, cdb_data = 0, cdb_src = 0.
//    - rst has priority over flush and over all handshakes.
//  - Holding buffer i (buf_valid, buf_tag, buf_data):
//    - req_ready[i] = !flush && (!buf_valid[i] || grant[i]).
//    - req_ready is combinational; it does not depend on req_valid.
//    - Capture at the edge when req_valid[i] && req_ready[i].
//    - A capture and a grant on the same buffer in one cycle is a legal refill: buf_valid stays 1, contents are replaced.
//  - Arbitration (combinational, one-hot grant):
//    - Candidates are the buffers with buf_valid = 1.
//    - Scan starts at rr_ptr and goes upward, wrapping modulo N_REQ; the first candidate found is granted.
//    - With no candidates, grant = 0.
//    - After a grant to i: rr_ptr <= (i+1) mod N_REQ. rr_ptr wraps from N_REQ-1 to 0.
//    - With no grant, rr_ptr holds its value.
//  - CDB output (registered):
//    - At each edge: cdb_valid <= |grant.
//    - When granted: cdb_tag/cdb_data/cdb_src <= granted buffer contents and index, and the granted buffer_valid clears unless refilled.
//    - When not granted: tag/data/src hold their last value; only cdb_valid drops.
//  - Latency:
//    - Accepted at edge N into an empty arbiter -> cdb_valid high in the cycle after edge N+1 (2 cycles).
//    - Sustained throughput is 1 broadcast per cycle.
//  - Fairness: a continuously valid buffer waits at most N_REQ-1 grants before its own.
//  - flush (synchronous):
//    - At the edge, all buf_valid <= 0 and cdb_valid <= 0.
//    - Grants computed in the flush cycle are discarded.
//    - Every req_ready is 0 in the flush cycle, so nothing is captured; rr_ptr is unchanged.
//  - rst or flush mid-stream: in-flight results are lost; no partial broadcast ever appears.
//  - Never more than one cdb_valid per cycle; a tag is broadcast exactly once per accepted request.
// TESTING
//  - Reset: hold rst 2 cycles with all req_valid=1 -> cdb_valid=0, cdb_tag=0, rr_ptr=0, no capture; req_ready=4'b1111 after release.
//  - Single: unit 2 sends tag 0x15, data 0xDEADBEEF at edge N -> after edge N+1: cdb_valid=1, cdb_tag=0x15, cdb_data=0xDEADBEEF, cdb_src=2; then cdb_valid=0.
//  - Round-robin: all 4 units valid for one cycle (tags 1,2,3,4), rr_ptr=0 -> broadcasts on 4 consecutive cycles in order src 0,1,2,3; rr_ptr ends at 0 (wrap).
//  - Backpressure/refill: units 0 and 3 send every cycle with incrementing tags for 8 cycles -> sources alternate 0,3,0,3; req_ready toggles per unit; no tag lost or duplicated.
//  - Flush: buffers 1 and 2 full, flush=1 for one cycle -> next cycle cdb_valid=0 and buf_valid=0; req_ready=0 during flush; neither tag is ever broadcast.
//  - Starvation bound: units 0,1,2 permanently valid, unit 3 arrives at a random cycle -> unit 3 is broadcast within 4 cycles.

Source files
------------

// File: rtl/cdb_writeback_arbiter.sv
// cdb_writeback_arbiter
// Shares the single Common Data Bus between the execution units
// (0=int, 1=mult, 2=div, 3=mem by default). Each unit parks its finished
// result (ROB tag + data) in a 1-entry holding buffer. A round-robin arbiter
// picks one buffered result per cycle and drives it onto a registered CDB.
//
// Handshake (per unit i): a result transfers at the rising edge where
// req_valid[i] && req_ready[i]. req_ready[i] is combinational from the
// buffer state and flush only; it never looks at req_valid[i]. A unit must
// hold req_valid/req_tag/req_data stable until the transfer happens.
module cdb_writeback_arbiter #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 6,
  parameter int N_REQ  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*TAG_W-1:0]    req_tag,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      cdb_valid,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic [DATA_W-1:0]         cdb_data,
  output logic [$clog2(N_REQ)-1:0]  cdb_src
);

  localparam int SRC_W = $clog2(N_REQ);

  // Holding buffers
  logic [N_REQ-1:0]  buf_valid_q, buf_valid_d;
  logic [TAG_W-1:0]  buf_tag_q  [N_REQ];
  logic [TAG_W-1:0]  buf_tag_d  [N_REQ];
  logic [DATA_W-1:0] buf_data_q [N_REQ];
  logic [DATA_W-1:0] buf_data_d [N_REQ];

  // Round-robin pointer: index where the next priority scan starts
  logic [SRC_W-1:0]  rr_ptr_q, rr_ptr_d;

  // Registered CDB
  logic              cdb_valid_q, cdb_valid_d;
  logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
  logic [DATA_W-1:0] cdb_data_q, cdb_data_d;
  logic [SRC_W-1:0]  cdb_src_q, cdb_src_d;

  // Arbitration results
  logic [N_REQ-1:0]  grant;
  logic              grant_any;
  logic [SRC_W-1:0]  grant_idx;

  // Scan scratch: rr_ptr + k needs one extra bit before the modulo wrap
  logic [SRC_W:0]    scan_sum;
  logic [SRC_W-1:0]  scan_idx;

  // Round-robin pick: first valid buffer at or above rr_ptr, wrapping
  always_comb begin
    grant     = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_sum = {1'b0, rr_ptr_q} + (SRC_W+1)'(k);
      if (scan_sum >= (SRC_W+1)'(N_REQ)) begin
        scan_sum = scan_sum - (SRC_W+1)'(N_REQ);
      end
      scan_idx = scan_sum[SRC_W-1:0];
      if (!grant_any && buf_valid_q[scan_idx]) begin
        grant_any       = 1'b1;
        grant[scan_idx] = 1'b1;
        grant_idx       = scan_idx;
      end
    end
  end

  // A buffer accepts when empty or being drained this cycle; flush blocks all
  assign req_ready = flush ? '0 : (~buf_valid_q | grant);

  // Next state: drain the granted buffer onto the CDB, then capture new results
  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_tag_d   = buf_tag_q;
    buf_data_d  = buf_data_q;
    rr_ptr_d    = rr_ptr_q;
    cdb_valid_d = 1'b0;
    cdb_tag_d   = cdb_tag_q;
    cdb_data_d  = cdb_data_q;
    cdb_src_d   = cdb_src_q;

    if (flush) begin
      // Drop everything buffered; the grant of this cycle is discarded and
      // the pointer does not move.
      buf_valid_d = '0;
      cdb_valid_d = 1'b0;
    end else begin
      cdb_valid_d = grant_any;
      if (grant_any) begin
        cdb_tag_d              = buf_tag_q[grant_idx];
        cdb_data_d             = buf_data_q[grant_idx];
        cdb_src_d              = grant_idx;
        buf_valid_d[grant_idx] = 1'b0;
        rr_ptr_d = (grant_idx == SRC_W'(N_REQ-1)) ? '0 : grant_idx + 1'b1;
      end
      // Capture after the drain so a same-cycle refill keeps the buffer full
      for (int i = 0; i < N_REQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          buf_valid_d[i] = 1'b1;
          buf_tag_d[i]   = req_tag[i*TAG_W +: TAG_W];
          buf_data_d[i]  = req_data[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Control and CDB registers, synchronous active-high reset
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid_q <= '0;
      rr_ptr_q    <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
      cdb_src_q   <= '0;
    end else begin
      buf_valid_q <= buf_valid_d;
      rr_ptr_q    <= rr_ptr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_data_q  <= cdb_data_d;
      cdb_src_q   <= cdb_src_d;
    end
  end

  // Buffer payload registers; contents are qualified by buf_valid_q
  always_ff @(posedge clk) begin
    buf_tag_q  <= buf_tag_d;
    buf_data_q <= buf_data_d;
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_data  = cdb_data_q;
  assign cdb_src   = cdb_src_q;

endmodule

// File: tb/tb_cdb_writeback_arbiter.sv
// Testbench for cdb_writeback_arbiter: directed scenarios, a behavioural
// model of buffers/pointer/CDB compared every cycle, tag scoreboard, and
// hand-computed literal expectations.
module tb_cdb_writeback_arbiter;

  localparam int DATA_W = 32;
  localparam int TAG_W  = 6;
  localparam int N_REQ  = 4;
  localparam int SRC_W  = 2;

  // ---------------- clock / reset ----------------
  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    flush = 1'b0;
  logic [N_REQ-1:0]        req_valid = '0;
  logic [N_REQ*TAG_W-1:0]  req_tag = '0;
  logic [N_REQ*DATA_W-1:0] req_data = '0;
  logic [N_REQ-1:0]        req_ready;
  logic                    cdb_valid;
  logic [TAG_W-1:0]        cdb_tag;
  logic [DATA_W-1:0]       cdb_data;
  logic [SRC_W-1:0]        cdb_src;

  always #5 clk = ~clk;

  cdb_writeback_arbiter #(.DATA_W(DATA_W), .TAG_W(TAG_W), .N_REQ(N_REQ)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_tag(req_tag), .req_data(req_data),
    .req_ready(req_ready),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data), .cdb_src(cdb_src)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit               m_live = 1'b0;
  bit               mv [N_REQ];
  logic [TAG_W-1:0] mt [N_REQ];
  logic [DATA_W-1:0] md [N_REQ];
  int               mrr;
  logic             mcv;
  logic [TAG_W-1:0] mct;
  logic [DATA_W-1:0] mcd;
  int               mcs;
  logic [N_REQ-1:0] m_rdy_s;
  int               m_g;

  // Oldest-turn-first pick: first occupied slot counting up from the pointer
  function automatic int m_pick();
    for (int k = 0; k < N_REQ; k++) begin
      if (mv[(mrr + k) % N_REQ]) return (mrr + k) % N_REQ;
    end
    return -1;
  endfunction

  function automatic logic [N_REQ-1:0] m_ready(input logic fl);
    logic [N_REQ-1:0] r;
    int g;
    g = m_pick();
    for (int i = 0; i < N_REQ; i++) r[i] = !fl && (!mv[i] || g == i);
    return r;
  endfunction

  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_live = 1'b1;
      for (int i = 0; i < N_REQ; i++) mv[i] = 1'b0;
      mrr = 0; mcv = 1'b0; mct = '0; mcd = '0; mcs = 0;
    end else begin
      m_rdy_s = m_ready(flush);
      m_g     = m_pick();
      if (flush) begin
        for (int i = 0; i < N_REQ; i++) mv[i] = 1'b0;
        mcv = 1'b0;
      end else begin
        if (m_g >= 0) begin
          mcv = 1'b1; mct = mt[m_g]; mcd = md[m_g]; mcs = m_g;
          mv[m_g] = 1'b0;
          mrr = (m_g + 1) % N_REQ;
        end else begin
          mcv = 1'b0;
        end
        for (int i = 0; i < N_REQ; i++) begin
          if (req_valid[i] && m_rdy_s[i]) begin
            mv[i] = 1'b1;
            mt[i] = req_tag[i*TAG_W +: TAG_W];
            md[i] = req_data[i*DATA_W +: DATA_W];
          end
        end
      end
    end
  end

  // ---------------- scoreboard / compare ----------------
  int               bc [64];
  logic [SRC_W-1:0] src_log[$];
  logic [TAG_W-1:0] exp_q[$];

  always @(negedge clk) begin
    if (m_live) begin
      chk("cdb_valid", cdb_valid, mcv);
      chk("cdb_tag",   cdb_tag,   mct);
      chk("cdb_data",  cdb_data,  mcd);
      chk("cdb_src",   cdb_src,   mcs);
      chk("req_ready", req_ready, m_ready(flush));
      if (cdb_valid) begin
        bc[cdb_tag] = bc[cdb_tag] + 1;
        src_log.push_back(cdb_src);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DATA_W-1:0] dat(input logic [TAG_W-1:0] t);
    return {2'b00, t, 2'b01, t, 2'b10, t, 2'b11, t};
  endfunction

  task automatic set_req(input int i, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
    req_valid[i]                = 1'b1;
    req_tag[i*TAG_W +: TAG_W]   = t;
    req_data[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic clear_sb();
    for (int i = 0; i < 64; i++) bc[i] = 0;
    src_log.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    req_valid = '0;
    flush = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  logic [TAG_W-1:0] t0, t3;
  logic [TAG_W-1:0] tu [3];
  logic [N_REQ-1:0] f;
  int arrival, w;
  bit acc, found;

  initial begin
    // Reset held 2 cycles with every unit requesting
    for (int i = 0; i < N_REQ; i++) set_req(i, TAG_W'(i + 1), dat(TAG_W'(i + 1)));
    step(); step();
    chk("rst_cdb_valid", cdb_valid, 1'b0);
    chk("rst_cdb_tag",   cdb_tag,   6'h0);
    chk("rst_cdb_src",   cdb_src,   2'd0);
    rst = 1'b0;
    req_valid = '0;
    #1;
    chk("rst_req_ready", req_ready, 4'b1111);
    step(); step();
    chk("rst_no_capture", cdb_valid, 1'b0);

    // Single result from unit 2
    clear_sb();
    set_req(2, 6'h15, 32'hDEADBEEF);
    step();
    req_valid = '0;
    step();
    chk("single_valid", cdb_valid, 1'b1);
    chk("single_tag",   cdb_tag,   6'h15);
    chk("single_data",  cdb_data,  32'hDEADBEEF);
    chk("single_src",   cdb_src,   2'd2);
    step();
    chk("single_drop",  cdb_valid, 1'b0);
    chk("single_hold",  cdb_tag,   6'h15);
    chk("single_once",  bc[6'h15], 1);

    // Round-robin over all four units from pointer 0
    do_reset();
    clear_sb();
    for (int i = 0; i < N_REQ; i++) set_req(i, TAG_W'(i + 1), dat(TAG_W'(i + 1)));
    step();
    req_valid = '0;
    for (int k = 0; k < N_REQ; k++) begin
      step();
      chk("rr_valid", cdb_valid, 1'b1);
      chk("rr_src",   cdb_src,   k);
      chk("rr_tag",   cdb_tag,   k + 1);
    end
    step();
    chk("rr_idle", cdb_valid, 1'b0);
    // Pointer wrapped to 0: unit 0 beats unit 3
    set_req(0, 6'h0A, dat(6'h0A));
    set_req(3, 6'h0B, dat(6'h0B));
    step();
    req_valid = '0;
    step();
    chk("rr_wrap_first",  cdb_src, 2'd0);
    step();
    chk("rr_wrap_second", cdb_src, 2'd3);
    step();

    // Backpressure / refill: units 0 and 3 every cycle for 8 cycles
    do_reset();
    clear_sb();
    t0 = 6'h10;
    t3 = 6'h30;
    for (int cyc = 0; cyc < 8; cyc++) begin
      set_req(0, t0, dat(t0));
      set_req(3, t3, dat(t3));
      if (cyc == 0) chk("bp_ready_c0", req_ready, 4'b1111);
      else chk("bp_ready_toggle", req_ready, (cyc % 2 == 1) ? 4'b0111 : 4'b1110);
      f = req_ready;
      if (f[0]) exp_q.push_back(t0);
      if (f[3]) exp_q.push_back(t3);
      step();
      if (f[0]) t0 = t0 + 1'b1;
      if (f[3]) t3 = t3 + 1'b1;
    end
    req_valid = '0;
    for (int k = 0; k < 4; k++) step();
    chk("bp_accept_count", exp_q.size(), 9);
    chk("bp_bcast_count", src_log.size(), 9);
    for (int k = 0; k < 4; k++) begin
      if (k < src_log.size()) chk("bp_alternate", src_log[k], (k % 2 == 0) ? 2'd0 : 2'd3);
      else chk("bp_alternate_missing", 1'b0, 1'b1);
    end
    foreach (exp_q[k]) chk("bp_tag_once", bc[exp_q[k]], 1);

    // Flush with buffers 1 and 2 full
    do_reset();
    clear_sb();
    set_req(1, 6'h21, dat(6'h21));
    set_req(2, 6'h22, dat(6'h22));
    step();
    req_valid = '0;
    flush = 1'b1;
    #1;
    chk("flush_ready", req_ready, 4'b0000);
    step();
    flush = 1'b0;
    #1;
    chk("flush_cdb_valid", cdb_valid, 1'b0);
    chk("flush_ready_after", req_ready, 4'b1111);
    step(); step(); step();
    chk("flush_drop_21", bc[6'h21], 0);
    chk("flush_drop_22", bc[6'h22], 0);

    // Starvation bound: units 0..2 always busy, unit 3 arrives late
    do_reset();
    clear_sb();
    arrival = $urandom_range(2, 10);
    tu[0] = 6'h00; tu[1] = 6'h10; tu[2] = 6'h20;
    acc = 1'b0; found = 1'b0; w = 0;
    for (int cyc = 0; cyc < 40 && !found; cyc++) begin
      for (int u = 0; u < 3; u++) set_req(u, tu[u], dat(tu[u]));
      if (cyc >= arrival && !acc) set_req(3, 6'h3F, dat(6'h3F));
      else req_valid[3] = 1'b0;
      f = req_valid & req_ready;
      step();
      if (acc) begin
        w++;
        if (cdb_valid && cdb_src == 2'd3) begin
          found = 1'b1;
          chk("starve_tag", cdb_tag, 6'h3F);
        end
      end
      if (f[3]) acc = 1'b1;
      for (int u = 0; u < 3; u++) if (f[u]) tu[u] = {tu[u][5:4], tu[u][3:0] + 4'd1};
    end
    req_valid = '0;
    chk("starve_found", found, 1'b1);
    chk("starve_bound", (w >= 1 && w <= 4), 1'b1);
    for (int k = 0; k < 4; k++) step();
    chk("starve_once", bc[6'h3F], 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
